// File: rtl/game_pkg.sv
// Shared VGA timing boundaries, palette and coordinate types for the
// cat-and-mouse display back end.
package game_pkg;

    // 640x480 @ 60 Hz raster boundaries (sync windows are half-open [start, end)).
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_MAX        = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_MAX        = 10'd524;

    localparam int BOARD_CELLS = 16;

    localparam logic [7:0] COL_CAT    = 8'hE0;
    localparam logic [7:0] COL_MOUSE  = 8'h1C;
    localparam logic [7:0] COL_GOAL   = 8'h03;
    localparam logic [7:0] COL_GRID   = 8'h49;
    localparam logic [7:0] COL_BORDER = 8'hFC;
    localparam logic [7:0] COL_BG     = 8'h00;

    typedef logic [3:0] cell_t;

    typedef struct packed {
        cell_t cat_x;
        cell_t cat_y;
        cell_t mouse_x;
        cell_t mouse_y;
        cell_t goal_x;
        cell_t goal_y;
        logic  game_over;
    } snap_t;

endpackage

// File: rtl/grid_renderer_vga_timing.sv
// Pixel-tick divider, 800x525 raster counters and the running cell
// sub-counters that locate the current pixel on the 16x16 board.
module vga_timing
    import game_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CELL_PX  = 30,
    parameter int X_OFFSET = 80
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       pix_tick_o,
    output logic [9:0] hcount_o,
    output logic [9:0] vcount_o,
    output cell_t      col_o,
    output cell_t      row_o,
    output logic       grid_o,
    output logic       in_board_o,
    output logic       visible_o,
    output logic       hsync_raw_o,
    output logic       vsync_raw_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
    localparam logic [9:0] X_START = 10'(X_OFFSET);
    localparam logic [9:0] X_END   = 10'(X_OFFSET + BOARD_CELLS * CELL_PX);
    localparam logic [9:0] Y_END   = 10'(BOARD_CELLS * CELL_PX);

    logic [DIV_W-1:0] div_q;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [SUB_W-1:0] xs_q, xs_d, ys_q, ys_d;
    cell_t            col_q, col_d, row_q, row_d;
    logic             pix_tick;
    logic             h_wrap;

    assign pix_tick = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every combinational output is given a default before any branch, so no path infers a latch.
        h_wrap = (h_q == H_MAX);
        h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d    = v_q;
        xs_d   = xs_q;
        col_d  = col_q;
        ys_d   = ys_q;
        row_d  = row_q;

        // Column tracking restarts exactly on the board's left edge.
        if (h_d == X_START) begin
            xs_d  = '0;
            col_d = '0;
        end else if (xs_q == SUB_LAST) begin
            xs_d  = '0;
            col_d = col_q + 4'd1;
        end else begin
            xs_d = xs_q + SUB_W'(1);
        end

        if (h_wrap) begin
            v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
            if (v_d == 10'd0) begin
                ys_d  = '0;
                row_d = '0;
            end else if (ys_q == SUB_LAST) begin
                ys_d  = '0;
                row_d = row_q + 4'd1;
            end else begin
                ys_d = ys_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            xs_q  <= '0;
            ys_q  <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            div_q <= pix_tick ? '0 : div_q + DIV_W'(1);
            if (pix_tick) begin
                h_q   <= h_d;
                v_q   <= v_d;
                xs_q  <= xs_d;
                ys_q  <= ys_d;
                col_q <= col_d;
                row_q <= row_d;
            end
        end
    end

    assign pix_tick_o  = pix_tick;
    assign hcount_o    = h_q;
    assign vcount_o    = v_q;
    assign col_o       = col_q;
    assign row_o       = row_q;
    assign grid_o      = (xs_q == '0) || (ys_q == '0);
    assign in_board_o  = (h_q >= X_START) && (h_q < X_END) && (v_q < Y_END);
    assign visible_o   = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
    assign hsync_raw_o = ~((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    assign vsync_raw_o = ~((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));

endmodule

// File: rtl/grid_renderer.sv
// VGA back end for the cat-and-mouse board: per-frame snapshot, colour priority and
// registered sync/colour outputs. Define GAMEOVER_FLASH_EN for a blinking game-over border.
module grid_renderer
    import game_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CELL_PX  = 30,
    parameter int X_OFFSET = 80
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] CatX,
    input  logic [3:0] CatY,
    input  logic [3:0] MouseX,
    input  logic [3:0] MouseY,
    input  logic [3:0] GoalX,
    input  logic [3:0] GoalY,
    input  logic       GameOver,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic       frame_start
);

    logic       pix_tick;
    logic [9:0] hcount, vcount;
    cell_t      col, row;
    logic       grid, in_board, visible, hsync_raw, vsync_raw;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .CELL_PX  (CELL_PX),
        .X_OFFSET (X_OFFSET)
    ) u_timing (
        .clk_i       (clock),
        .rst_i       (reset),
        .pix_tick_o  (pix_tick),
        .hcount_o    (hcount),
        .vcount_o    (vcount),
        .col_o       (col),
        .row_o       (row),
        .grid_o      (grid),
        .in_board_o  (in_board),
        .visible_o   (visible),
        .hsync_raw_o (hsync_raw),
        .vsync_raw_o (vsync_raw)
    );

    snap_t      snap_q, snap_d;
    logic       snapshot;
    logic       border_on;
    logic       cat_hit, mouse_hit, goal_hit;
    logic [7:0] rgb_d;
    logic       hsync_q, vsync_q, frame_start_q;
    logic [7:0] rgb_q;

    // Latch game state at the start of vertical blanking so a frame never tears.
    assign snapshot = pix_tick && (hcount == 10'd0) && (vcount == V_VISIBLE);

    always_comb begin
        snap_d = '{cat_x:   CatX,   cat_y:   CatY,
                   mouse_x: MouseX, mouse_y: MouseY,
                   goal_x:  GoalX,  goal_y:  GoalY,
                   game_over: GameOver};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else if (snapshot) begin
            snap_q <= snap_d;
        end
    end

`ifdef GAMEOVER_FLASH_EN
    logic [4:0] frame_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (snapshot) begin
            frame_cnt_q <= frame_cnt_q + 5'd1;
        end
    end

    assign border_on = snap_q.game_over & ~frame_cnt_q[4];
`else
    assign border_on = snap_q.game_over;
`endif

    assign cat_hit   = (col == snap_q.cat_x)   && (row == snap_q.cat_y);
    assign mouse_hit = (col == snap_q.mouse_x) && (row == snap_q.mouse_y);
    assign goal_hit  = (col == snap_q.goal_x)  && (row == snap_q.goal_y);

    always_comb begin
        rgb_d = COL_BG;
        if (visible) begin
            if (in_board) begin
                if (cat_hit)        rgb_d = COL_CAT;
                else if (mouse_hit) rgb_d = COL_MOUSE;
                else if (goal_hit)  rgb_d = COL_GOAL;
                else if (grid)      rgb_d = COL_GRID;
            end else if (border_on) begin
                rgb_d = COL_BORDER;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= COL_BG;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_tick && (hcount == 10'd0) && (vcount == 10'd0);
            if (pix_tick) begin
                hsync_q <= hsync_raw;
                vsync_q <= vsync_raw;
                rgb_q   <= rgb_d;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Bench for grid_renderer: a pixel-arithmetic reference model checked every clock,
// plus hand-computed pixel, sync and frame-pulse expectations.
`timescale 1ns/1ps
module tb_grid_renderer;

    localparam int D           = 2;
    localparam int FRAME_TICKS = 800 * 525;
    localparam int MAX_FAILS   = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cat_x, cat_y, mouse_x, mouse_y, goal_x, goal_y;
    logic       game_over;
    logic       hsync, vsync, frame_start;
    logic [7:0] rgb;

    grid_renderer #(
        .CLK_DIV  (D),
        .CELL_PX  (30),
        .X_OFFSET (80)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .CatX        (cat_x),
        .CatY        (cat_y),
        .MouseX      (mouse_x),
        .MouseY      (mouse_y),
        .GoalX       (goal_x),
        .GoalY       (goal_y),
        .GameOver    (game_over),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
            if (n_fail >= MAX_FAILS) finish_test();
        end
    endtask

    // Reference model: counts clocks since reset, derives raster position by
    // plain division and paints each pixel from the colour rules.
    int         m_clk = 0, m_ticks = 0, m_frames = 0;
    logic       m_hs = 1'b1, m_vs = 1'b1, m_fs = 1'b0;
    logic [7:0] m_rgb = 8'h00;
    int         s_cx = 0, s_cy = 0, s_mx = 0, s_my = 0, s_gx = 0, s_gy = 0, s_go = 0;

    function automatic int pos_x(input int n);
        return (n % FRAME_TICKS) % 800;
    endfunction

    function automatic int pos_y(input int n);
        return (n % FRAME_TICKS) / 800;
    endfunction

    function automatic logic [7:0] ref_colour(input int x, input int y);
        int col, row;
        if (x >= 640 || y >= 480) return 8'h00;
        if (x < 80 || x >= 80 + 16 * 30 || y >= 16 * 30) begin
            if (s_go == 0) return 8'h00;
`ifdef GAMEOVER_FLASH_EN
            if ((m_frames % 32) >= 16) return 8'h00;
`endif
            return 8'hFC;
        end
        col = (x - 80) / 30;
        row = y / 30;
        if (col == s_cx && row == s_cy) return 8'hE0;
        if (col == s_mx && row == s_my) return 8'h1C;
        if (col == s_gx && row == s_gy) return 8'h03;
        if ((x - 80) % 30 == 0 || y % 30 == 0) return 8'h49;
        return 8'h00;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clk    <= 0;
            m_ticks  <= 0;
            m_frames <= 0;
            m_hs     <= 1'b1;
            m_vs     <= 1'b1;
            m_fs     <= 1'b0;
            m_rgb    <= 8'h00;
            s_cx <= 0; s_cy <= 0; s_mx <= 0; s_my <= 0; s_gx <= 0; s_gy <= 0; s_go <= 0;
        end else begin
            m_clk <= m_clk + 1;
            m_fs  <= 1'b0;
            if ((m_clk + 1) % D == 0) begin
                m_fs  <= (m_ticks % FRAME_TICKS) == 0;
                m_hs  <= !(pos_x(m_ticks) >= 656 && pos_x(m_ticks) < 752);
                m_vs  <= !(pos_y(m_ticks) >= 490 && pos_y(m_ticks) < 492);
                m_rgb <= ref_colour(pos_x(m_ticks), pos_y(m_ticks));
                if (pos_x(m_ticks) == 0 && pos_y(m_ticks) == 480) begin
                    s_cx <= int'(cat_x);   s_cy <= int'(cat_y);
                    s_mx <= int'(mouse_x); s_my <= int'(mouse_y);
                    s_gx <= int'(goal_x);  s_gy <= int'(goal_y);
                    s_go <= int'(game_over);
                    m_frames <= m_frames + 1;
                end
                m_ticks <= m_ticks + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en)
            check("model {hs,vs,fs,rgb}", int'({hsync, vsync, frame_start, rgb}),
                  int'({m_hs, m_vs, m_fs, m_rgb}));
    end

    // Clock edge (counted from reset release) that registers raster tick n.
    function automatic int tick_clk(input int n);
        return (n + 1) * D;
    endfunction

    task automatic wait_to(input int target);
        int budget;
        budget = 4_000_000;
        while (m_clk < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (m_clk != target) begin
            n_fail++;
            $display("FAIL wait_to: reached clock %0d, wanted %0d", m_clk, target);
        end
    endtask

    task automatic pix(input int frame, input int x, input int y, input int exp, input string name);
        wait_to(tick_clk(frame * FRAME_TICKS + y * 800 + x));
        check(name, int'(rgb), exp);
    endtask

    task automatic measure_hsync(input int prev_fall);
        int budget, t_fall, t_rise;
        budget = 4000;
        while (hsync !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
        t_fall = m_clk;
        while (hsync !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
        t_rise = m_clk;
        check("hsync low width (clocks)", t_rise - t_fall, 96 * D);
        check("hsync period (clocks)", t_fall - prev_fall, 800 * D);
    endtask

    initial begin
        cat_x = 4'd0;   cat_y = 4'd0;
        mouse_x = 4'd15; mouse_y = 4'd15;
        goal_x = 4'd5;  goal_y = 4'd3;
        game_over = 1'b0;
        rst = 1'b1;
        #20 cmp_en = 1'b1;
        #1;
        check("hsync in reset", int'(hsync), 1);
        check("vsync in reset", int'(vsync), 1);
        check("rgb in reset", int'(rgb), 0);
        check("frame_start in reset", int'(frame_start), 0);
        repeat (8) @(negedge clk);
        #1 rst = 1'b0;

        // First tick lands D clocks after release and starts frame 0.
        wait_to(D - 1);  check("frame_start before first tick", int'(frame_start), 0);
        wait_to(D);      check("frame_start on first tick", int'(frame_start), 1);
        wait_to(D + 1);  check("frame_start one clock wide", int'(frame_start), 0);

        // Frame 0 renders the reset snapshot: all tokens at (0,0), cat wins.
        pix(0, 80, 0, 8'hE0, "f0 cat covers grid corner");
        wait_to(tick_clk(655)); check("hsync high at h=655", int'(hsync), 1);
        wait_to(tick_clk(656)); check("hsync low at h=656", int'(hsync), 0);
        wait_to(tick_clk(751)); check("hsync low at h=751", int'(hsync), 0);
        wait_to(tick_clk(752)); check("hsync high at h=752", int'(hsync), 1);
        measure_hsync(tick_clk(656));
        pix(0, 85, 5, 8'hE0, "f0 cat (85,5)");
        pix(0, 20, 20, 8'h00, "f0 outside board (20,20)");
        pix(0, 110, 50, 8'h49, "f0 grid (110,50)");

        wait_to(tick_clk(490 * 800) - 1); check("vsync high before line 490", int'(vsync), 1);
        wait_to(tick_clk(490 * 800));     check("vsync low at line 490", int'(vsync), 0);
        wait_to(tick_clk(492 * 800 - 1)); check("vsync low at end of line 491", int'(vsync), 0);
        wait_to(tick_clk(492 * 800));     check("vsync high at line 492", int'(vsync), 1);

        wait_to(tick_clk(FRAME_TICKS) - 1); check("frame_start low before frame 1", int'(frame_start), 0);
        wait_to(tick_clk(FRAME_TICKS));     check("frame_start at frame 1", int'(frame_start), 1);

        // Frame 1: Cat (0,0), Mouse (15,15), Goal (5,3).
        pix(1, 85, 5, 8'hE0, "f1 cat (85,5)");
        pix(1, 20, 20, 8'h00, "f1 no border (20,20)");
        pix(1, 110, 50, 8'h49, "f1 grid (110,50)");
        pix(1, 235, 95, 8'h03, "f1 goal (235,95)");
        wait_to(tick_clk(FRAME_TICKS + 100 * 800));
        #1;
        cat_x = 4'd7; cat_y = 4'd7; mouse_x = 4'd7; mouse_y = 4'd7; game_over = 1'b1;
        pix(1, 555, 475, 8'h1C, "f1 mouse held until snapshot");
        pix(1, 20, 479, 8'h00, "f1 no border before snapshot");

        // Frame 2: cat and mouse overlap at (7,7); CatX moves mid-frame.
        pix(2, 20, 20, 8'hFC, "f2 game-over border");
        wait_to(tick_clk(2 * FRAME_TICKS + 200 * 800));
        #1 cat_x = 4'd8;
        pix(2, 305, 225, 8'hE0, "f2 cat over mouse (7,7)");
        pix(2, 335, 225, 8'h00, "f2 cell (8,7) still empty");

        // Frame 3: cat now at (8,7), mouse revealed at (7,7).
        pix(3, 20, 20, 8'hFC, "f3 border");
        pix(3, 305, 225, 8'h1C, "f3 mouse (7,7)");
        pix(3, 335, 225, 8'hE0, "f3 cat (8,7)");
        pix(3, 0, 300, 8'hFC, "f3 border before reset");

        #1 rst = 1'b1;
        #1;
        check("hsync after mid-frame reset", int'(hsync), 1);
        check("vsync after mid-frame reset", int'(vsync), 1);
        check("rgb after mid-frame reset", int'(rgb), 0);
        check("frame_start after mid-frame reset", int'(frame_start), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        wait_to(D - 1); check("frame_start low after reset", int'(frame_start), 0);
        wait_to(D);     check("frame_start D clocks after reset", int'(frame_start), 1);
        pix(0, 85, 5, 8'hE0, "post-reset cat at (0,0)");
        pix(0, 20, 20, 8'h00, "post-reset border cleared");

        finish_test();
    end

endmodule
